// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the fetch PC. Advances it sequentially under the
// fetch ready handshake. Redirects it on taken branches and jumps resolved in
// execute, then holds fetch idle for FLUSH_CYCLES bubbles.
//
// Optional build macro: MISALIGN_TRAP_EN
//   defined   - a redirect target with target[1:0] != 0 goes to TRAP_VEC and
//               pulses trap alongside flush.
//   undefined - target[1:0] is forced to 00 and trap is tied low.
//
// CNT_INIT is the reset value of redirect_cnt. It is left at 0 in normal use.
// A nonzero value is a bring-up aid for exercising counter saturation.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | out of reset, fetch not yet requested
// RUN   | pc is a live fetch request; execute may redirect
// FLUSH | bubbles after a redirect; fetch idle and ex_valid ignored

module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0010,
    parameter logic [15:0] CNT_INIT     = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [6:0]  alu_code,
    input  logic        br_taken,
    input  logic [31:0] npc_op1,
    input  logic [31:0] npc_op2,
    input  logic        if_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        trap,
    output logic [15:0] redirect_cnt
);

    // Control-transfer encodings shared with the execute stage.
    localparam logic [6:0] ALU_JAL  = 7'h40;
    localparam logic [6:0] ALU_JALR = 7'h41;
    localparam logic [6:0] ALU_BEQ  = 7'h50;
    localparam logic [6:0] ALU_BNE  = 7'h51;
    localparam logic [6:0] ALU_BLT  = 7'h52;
    localparam logic [6:0] ALU_BGE  = 7'h53;
    localparam logic [6:0] ALU_BLTU = 7'h54;
    localparam logic [6:0] ALU_BGEU = 7'h55;

    localparam logic [2:0] BUBBLE_LOAD = 3'(FLUSH_CYCLES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  bubble_q, bubble_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        trap_q, trap_d;
    logic [15:0] cnt_q, cnt_d;

    logic        is_branch;
    logic        take;
    logic [31:0] target;

    // Decode the resolved instruction and form the aligned redirect target.
    always_comb begin
        is_branch = (alu_code == ALU_BEQ)  || (alu_code == ALU_BNE)  ||
                    (alu_code == ALU_BLT)  || (alu_code == ALU_BGE)  ||
                    (alu_code == ALU_BLTU) || (alu_code == ALU_BGEU);
        take      = ex_valid && (state_q == RUN) &&
                    ((alu_code == ALU_JAL) || (alu_code == ALU_JALR) ||
                     (is_branch && br_taken));
        target    = npc_op1 + npc_op2;
        if (alu_code == ALU_JALR) begin
            target[0] = 1'b0;
        end
`ifndef MISALIGN_TRAP_EN
        target[1:0] = 2'b00;
`endif
    end

    // Next-state and next-output logic; a redirect takes priority over a
    // sequential advance in the same cycle.
    always_comb begin
        state_d  = state_q;
        bubble_d = bubble_q;
        pc_d     = pc_q;
        flush_d  = 1'b0;
        trap_d   = 1'b0;
        cnt_d    = cnt_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (take) begin
                    pc_d     = target;
`ifdef MISALIGN_TRAP_EN
                    if (target[1:0] != 2'b00) begin
                        pc_d   = TRAP_VEC;
                        trap_d = 1'b1;
                    end
`endif
                    flush_d  = 1'b1;
                    bubble_d = BUBBLE_LOAD;
                    state_d  = FLUSH;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (if_ready) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            FLUSH: begin
                if (bubble_q <= 3'd1) begin
                    bubble_d = 3'd0;
                    state_d  = RUN;
                end else begin
                    bubble_d = bubble_q - 3'd1;
                end
            end
            default: begin
                state_d  = BOOT;
                bubble_d = 3'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= BOOT;
            bubble_q <= 3'd0;
            pc_q     <= RESET_PC;
            flush_q  <= 1'b0;
            trap_q   <= 1'b0;
            cnt_q    <= CNT_INIT;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            trap_q   <= trap_d;
            cnt_q    <= cnt_d;
        end
    end

`ifndef MISALIGN_TRAP_EN
    logic unused_trap_vec;
    assign unused_trap_vec = ^TRAP_VEC;
`endif

    assign pc           = pc_q;
    assign pc_valid     = (state_q == RUN);
    assign flush        = flush_q;
    assign trap         = trap_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Testbench for pc_redirect_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the fetch PC.
module tb_pc_redirect_unit;

    localparam logic [31:0] RESET_PC     = 32'h0000_0000;
    localparam int          FLUSH_CYCLES = 2;
    localparam logic [31:0] TRAP_VEC     = 32'h0000_0010;
    localparam logic [15:0] SAT_INIT     = 16'hFFFD;

    localparam logic [6:0] ALU_ADD  = 7'h00;
    localparam logic [6:0] ALU_SUB  = 7'h01;
    localparam logic [6:0] ALU_AND  = 7'h02;
    localparam logic [6:0] ALU_LUI  = 7'h10;
    localparam logic [6:0] ALU_JAL  = 7'h40;
    localparam logic [6:0] ALU_JALR = 7'h41;
    localparam logic [6:0] ALU_BEQ  = 7'h50;
    localparam logic [6:0] ALU_BNE  = 7'h51;
    localparam logic [6:0] ALU_BLT  = 7'h52;
    localparam logic [6:0] ALU_BGE  = 7'h53;
    localparam logic [6:0] ALU_BLTU = 7'h54;
    localparam logic [6:0] ALU_BGEU = 7'h55;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic [6:0]  alu_code = ALU_ADD;
    logic        br_taken = 1'b0;
    logic [31:0] npc_op1 = 32'h0;
    logic [31:0] npc_op2 = 32'h4;
    logic        if_ready = 1'b0;

    logic [31:0] pc, pc_s;
    logic        pc_valid, pc_valid_s;
    logic        flush, flush_s;
    logic        trap, trap_s;
    logic [15:0] redirect_cnt, redirect_cnt_s;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_code(alu_code),
        .br_taken(br_taken), .npc_op1(npc_op1), .npc_op2(npc_op2),
        .if_ready(if_ready), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .trap(trap), .redirect_cnt(redirect_cnt)
    );

    pc_redirect_unit #(.CNT_INIT(SAT_INIT)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_code(alu_code),
        .br_taken(br_taken), .npc_op1(npc_op1), .npc_op2(npc_op2),
        .if_ready(if_ready), .pc(pc_s), .pc_valid(pc_valid_s), .flush(flush_s),
        .trap(trap_s), .redirect_cnt(redirect_cnt_s)
    );

    int checks = 0;
    int errors = 0;

    // Model: fetch PC, whether fetch has started, bubbles still owed,
    // last-cycle pulses and the two redirect counters.
    logic [31:0] m_pc;
    bit          m_started;
    int          m_bubbles;
    bit          m_flush, m_trap;
    int          m_cnt, m_cnt_sat;

    logic [6:0] codes [12] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_LUI, ALU_JAL, ALU_JALR,
                               ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_started = 0;
        m_bubbles = 0;
        m_flush   = 0;
        m_trap    = 0;
        m_cnt     = 0;
        m_cnt_sat = SAT_INIT;
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("pc_valid", {31'b0, pc_valid}, {31'b0, (m_started && m_bubbles == 0)});
        chk("flush", {31'b0, flush}, {31'b0, m_flush});
        chk("trap", {31'b0, trap}, {31'b0, m_trap});
        chk("redirect_cnt", {16'b0, redirect_cnt}, m_cnt);
        chk("redirect_cnt_sat", {16'b0, redirect_cnt_s}, m_cnt_sat);
    endtask

    // Apply the current inputs across one clock edge, advance the model,
    // then compare at the following falling edge.
    task automatic cycle();
        bit          is_xfer;
        logic [31:0] tgt;
        is_xfer = (alu_code == ALU_JAL) || (alu_code == ALU_JALR) ||
                  (br_taken && (alu_code inside {ALU_BEQ, ALU_BNE, ALU_BLT,
                                                 ALU_BGE, ALU_BLTU, ALU_BGEU}));
        tgt = npc_op1 + npc_op2;
        if (alu_code == ALU_JALR) tgt = tgt & ~32'h1;
        @(posedge clk);
        @(negedge clk);
        m_flush = 0;
        m_trap  = 0;
        if (!m_started) begin
            m_started = 1;
        end else if (m_bubbles > 0) begin
            m_bubbles = m_bubbles - 1;
        end else if (ex_valid && is_xfer) begin
`ifdef MISALIGN_TRAP_EN
            if (tgt % 4 != 0) begin
                m_pc   = TRAP_VEC;
                m_trap = 1;
            end else begin
                m_pc = tgt;
            end
`else
            m_pc = tgt & ~32'h3;
`endif
            m_flush   = 1;
            m_bubbles = FLUSH_CYCLES;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (m_cnt_sat < 65535) m_cnt_sat = m_cnt_sat + 1;
        end else if (if_ready) begin
            m_pc = m_pc + 32'd4;
        end
        compare_all();
    endtask

    task automatic set_op(input logic v, input logic [6:0] code, input logic bt,
                          input logic [31:0] a, input logic [31:0] b, input logic rdy);
        ex_valid = v;
        alu_code = code;
        br_taken = bt;
        npc_op1  = a;
        npc_op2  = b;
        if_ready = rdy;
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset pc", pc, RESET_PC);
        chk("reset pc_valid", {31'b0, pc_valid}, 32'd0);
        chk("reset flush", {31'b0, flush}, 32'd0);
        chk("reset trap", {31'b0, trap}, 32'd0);
        chk("reset cnt", {16'b0, redirect_cnt}, 32'd0);

        // Reset release with fetch always ready: 0x0, 0x4, 0x8.
        if_ready = 1'b1;
        rst_n = 1'b1;
        cycle();
        chk("boot pc_valid", {31'b0, pc_valid}, 32'd1);
        chk("boot pc", pc, 32'h0);
        cycle();
        chk("seq pc1", pc, 32'h4);
        cycle();
        chk("seq pc2", pc, 32'h8);

        // Taken BEQ with fetch ready in the same cycle.
        set_op(1, ALU_BEQ, 1, 32'h100, 32'h20, 1);
        cycle();
        chk("beq pc", pc, 32'h120);
        chk("beq flush", {31'b0, flush}, 32'd1);
        chk("beq bubble1", {31'b0, pc_valid}, 32'd0);
        chk("beq cnt", {16'b0, redirect_cnt}, 32'd1);
        set_op(0, ALU_ADD, 0, 32'h0, 32'h4, 1);
        cycle();
        chk("beq bubble2", {31'b0, pc_valid}, 32'd0);
        chk("beq flush low", {31'b0, flush}, 32'd0);
        cycle();
        chk("beq resume valid", {31'b0, pc_valid}, 32'd1);
        chk("beq resume pc", pc, 32'h120);
        cycle();
        chk("beq advance", pc, 32'h124);

        // Not-taken BNE and ADD with br_taken high never redirect.
        set_op(1, ALU_BNE, 0, 32'h124, 32'h4, 1);
        cycle();
        chk("bne pc", pc, 32'h128);
        chk("bne flush", {31'b0, flush}, 32'd0);
        set_op(1, ALU_ADD, 1, 32'h128, 32'h4, 1);
        cycle();
        chk("add pc", pc, 32'h12C);
        chk("add cnt", {16'b0, redirect_cnt}, 32'd1);

        // JALR clears bit 0; a JAL during the bubbles is ignored.
        set_op(1, ALU_JALR, 0, 32'h203, 32'h2, 1);
        cycle();
        chk("jalr pc", pc, 32'h204);
        chk("jalr flush", {31'b0, flush}, 32'd1);
        set_op(1, ALU_JAL, 0, 32'h400, 32'h0, 1);
        cycle();
        chk("jal in flush pc", pc, 32'h204);
        chk("jal in flush cnt", {16'b0, redirect_cnt}, 32'd2);
        set_op(0, ALU_ADD, 0, 32'h0, 32'h4, 0);
        cycle();
        chk("jalr resume pc", pc, 32'h204);
        cycle();
        chk("hold without ready", pc, 32'h204);

        // Wrap from 0xFFFF_FFFC to 0.
        set_op(1, ALU_JAL, 0, 32'hFFFF_FFF0, 32'hC, 0);
        cycle();
        set_op(0, ALU_ADD, 0, 32'h0, 32'h4, 0);
        cycle();
        cycle();
        chk("wrap start", pc, 32'hFFFF_FFFC);
        if_ready = 1'b1;
        cycle();
        chk("wrap to zero", pc, 32'h0);

        // Misaligned JAL target.
        set_op(1, ALU_JAL, 0, 32'h100, 32'h2, 1);
        cycle();
        chk("mis flush", {31'b0, flush}, 32'd1);
`ifdef MISALIGN_TRAP_EN
        chk("mis pc", pc, 32'h10);
        chk("mis trap", {31'b0, trap}, 32'd1);
`else
        chk("mis pc", pc, 32'h100);
        chk("mis trap", {31'b0, trap}, 32'd0);
`endif
        chk("cnt four", {16'b0, redirect_cnt}, 32'd4);
        chk("cnt saturated", {16'b0, redirect_cnt_s}, 32'hFFFF);

        // Asynchronous reset while flushing.
        set_op(0, ALU_ADD, 0, 32'h0, 32'h4, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async pc", pc, RESET_PC);
        chk("async flush", {31'b0, flush}, 32'd0);
        chk("async pc_valid", {31'b0, pc_valid}, 32'd0);
        chk("async cnt", {16'b0, redirect_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("post reset pc", pc, RESET_PC);
        chk("post reset valid", {31'b0, pc_valid}, 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case ($urandom_range(0, 2))
                0: b = 32'h4;
                1: b = {{20{1'b0}}, 12'($urandom_range(0, 4095))};
                default: b = $urandom();
            endcase
            set_op(1'($urandom_range(0, 1)), codes[$urandom_range(0, 11)],
                   1'($urandom_range(0, 1)), a, b, ($urandom_range(0, 9) < 7));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
